// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I-subset datapath.
// Optional retired-instruction counter is built only when PERF_CNT_EN is defined.
module multicycle_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  op,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ImmSrc,
  output logic [2:0]  ALUControl,
  output logic        done,
  output logic [31:0] instret
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_RETWB,
    S_LUI, S_HALT
  } state_t;

  state_t state, nxt;
  logic   pcw, mw, irw, rw;

  // Shared ALU decode for R and I types; only R-type honours func7 for sub.
  function automatic logic [2:0] alu_dec(input logic [6:0] o, input logic [2:0] f3,
                                         input logic [6:0] f7);
    case (f3)
      3'b000:  alu_dec = (o == OP_R && f7 == 7'b0100000) ? 3'b001 : 3'b000;
      3'b111:  alu_dec = 3'b010;
      3'b110:  alu_dec = 3'b011;
      3'b010:  alu_dec = 3'b101;
      default: alu_dec = 3'b000;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_FETCH;
    else     state <= nxt;

  always_comb begin
    nxt        = state;
    pcw        = 1'b0;
    mw         = 1'b0;
    irw        = 1'b0;
    rw         = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = 3'b000;
    ALUControl = 3'b000;
    done       = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irw       = mem_ready;
        pcw       = mem_ready;
        if (mem_ready) nxt = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_JAL) ? 3'b011 : 3'b010;
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = S_EXECR;
          OP_I:         nxt = S_EXECI;
          OP_B:         nxt = S_BRANCH;
          OP_JAL:       nxt = S_JAL;
          OP_JALR:      nxt = S_JALR;
          OP_LUI:       nxt = S_LUI;
          default:      nxt = S_HALT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_SW) ? 3'b001 : 3'b000;
        nxt     = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) nxt = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        rw        = 1'b1;
        nxt       = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mw     = 1'b1;
        if (mem_ready) nxt = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec(op, func3, func7);
        nxt        = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec(op, func3, func7);
        nxt        = S_ALUWB;
      end
      S_ALUWB: begin
        rw  = 1'b1;
        nxt = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        pcw        = (func3 == 3'b000 && zero) || (func3 == 3'b001 && !zero);
        nxt        = S_FETCH;
      end
      S_JAL: begin
        pcw = 1'b1;
        nxt = S_RETWB;
      end
      S_JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pcw       = 1'b1;
        nxt       = S_RETWB;
      end
      S_RETWB: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        rw        = 1'b1;
        nxt       = S_FETCH;
      end
      S_LUI: begin
        ALUSrcB    = 2'b01;
        ImmSrc     = 3'b100;
        ALUControl = 3'b100;
        nxt        = S_ALUWB;
      end
      S_HALT: done = 1'b1;
      default: nxt = S_FETCH;
    endcase
  end

  // Write enables are gated by rst so an interrupted store drops immediately.
  assign PCWrite  = pcw & ~rst;
  assign MemWrite = mw  & ~rst;
  assign IRWrite  = irw & ~rst;
  assign RegWrite = rw  & ~rst;

`ifdef PERF_CNT_EN
  logic [31:0] cnt;
  logic        retire;
  assign retire = (nxt == S_FETCH) &&
                  (state == S_MEMWB || state == S_MEMWRITE || state == S_ALUWB ||
                   state == S_BRANCH || state == S_RETWB);
  always_ff @(posedge clk or posedge rst)
    if (rst)         cnt <= '0;
    else if (retire) cnt <= cnt + 32'd1;
  assign instret = cnt;
`else
  assign instret = '0;
`endif

endmodule
